// File: rtl/adder_collector_pkg.sv
// Shared types and constants for the adder result collector: FSM states,
// result-word field offsets and internal widths.
package adder_collector_pkg;

    typedef enum logic {
        S_DATA = 1'b0,
        S_SUM  = 1'b1
    } state_t;

    localparam logic [14:0] MARKER_DEFAULT = 15'h0fff;

    localparam int ACC_W   = 24;
    localparam int CCNT_W  = 8;
    localparam int ENTRY_W = 17;

    localparam int COUT_BIT = 31;
    localparam int MARK_HI  = 30;
    localparam int MARK_LO  = 16;

endpackage

// File: rtl/adder_collector_fifo.sv
// Synchronous show-ahead FIFO: the head entry is always presented on o_rd_data
// straight from the storage registers; a push is accepted when full if a pop happens too.
module adder_collector_fifo #(
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 17
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_data,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_rd_data,
    output logic               o_full,
    output logic               o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               w_do_push;
    logic               w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/adder_result_collector.sv
// Collects {cout, marker, sum} adder results, buffers them and streams them out with a
// per-frame summary beat. Define ADDER_COLLECTOR_ERRCNT_EN to enable the marker check.
module adder_result_collector
    import adder_collector_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 8,
    parameter int          FRAME_LEN = 4,
    parameter logic [14:0] MARKER    = MARKER_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             ovf,
    output logic [7:0]       err_cnt
);

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ACC_W-1:0]    r_acc;
    logic [CCNT_W-1:0]   r_ccnt;
    logic [7:0]          r_beat;
    logic                r_ovf;
    logic                w_good;
    logic                w_full;
    logic                w_empty;
    logic                w_xfer;
    logic                w_pop;
    logic [ENTRY_W-1:0]  w_entry;
    logic [ENTRY_W-1:0]  w_head;

`ifdef ADDER_COLLECTOR_ERRCNT_EN
    logic [7:0] r_err_cnt;
    logic       w_bad;

    assign w_good = in_valid && (in_data[MARK_HI:MARK_LO] == MARKER);
    assign w_bad  = in_valid && (in_data[MARK_HI:MARK_LO] != MARKER);

    always_ff @(posedge clk) begin
        if (!rst)                          r_err_cnt <= 8'h00;
        else if (w_bad && r_err_cnt != 8'hff) r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_marker;

    // Marker field is not checked in this build; every qualified word is good.
    assign w_good          = in_valid;
    assign w_unused_marker = ^(in_data[MARK_HI:MARK_LO] ^ MARKER);
    assign err_cnt         = 8'h00;
`endif

    assign w_entry = {in_data[COUT_BIT], in_data[15:0]};
    assign w_xfer  = out_valid && out_ready;
    assign w_pop   = (r_state == S_DATA) && w_xfer;
    assign ovf     = r_ovf;

    adder_collector_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_good),
        .i_data    (w_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        case (r_state)
            S_DATA: begin
                out_valid = !w_empty;
                if (!w_empty) out_data = {15'h0000, w_head};
                if (w_xfer && r_beat == LAST_BEAT) w_state_nxt = S_SUM;
            end
            S_SUM: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = {r_ccnt, r_acc};
                if (w_xfer) w_state_nxt = S_DATA;
            end
            default: w_state_nxt = S_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_DATA;
            r_acc   <= '0;
            r_ccnt  <= '0;
            r_beat  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Overflow only when the word could not take the slot freed by a pop.
            if (w_good && w_full && !w_pop) r_ovf <= 1'b1;
            if (w_pop) begin
                r_acc  <= r_acc + ACC_W'(w_head[15:0]);
                r_ccnt <= r_ccnt + CCNT_W'(w_head[16]);
                r_beat <= (r_beat == LAST_BEAT) ? 8'd0 : r_beat + 8'd1;
            end else if (r_state == S_SUM && w_xfer) begin
                r_acc  <= '0;
                r_ccnt <= '0;
            end
        end
    end

endmodule
